// File: rtl/pcs_pattern_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pattern_pkg
// Shared types and constants for the PCS loopback pattern generator/checker.
//   lane_state_t : per-lane checker state (HUNT / VERIFY / LOCKED)
//   LCW          : width of the lock / unlock run counters (covers 1..15)
// -----------------------------------------------------------------------------
package pcs_pattern_pkg;

    localparam int unsigned LCW = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lane_state_t;

endpackage

// File: rtl/pcs_lane_checker.sv
// -----------------------------------------------------------------------------
// pcs_lane_checker
// One byte lane of the self-synchronising pattern checker. It seeds on a
// received byte, verifies LOCK_CNT consecutive increments and then tracks the
// incrementing stream, counting errors and dropping lock after UNLOCK_CNT
// consecutive mismatches. Round-trip latency is captured on lock entry.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rx_valid, rx   decoded receive byte and its qualifier
//   gen            generator value currently driven on this lane
//   clr_cnt        clears the error counter (wins over a same-cycle error)
//   lock           lane is locked
//   err_cnt        saturating error count
//   lat            (gen - rx) mod 256 captured when lock is acquired
// -----------------------------------------------------------------------------
module pcs_lane_checker
    import pcs_pattern_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx,
    input  logic [7:0]    gen,
    input  logic          clr_cnt,
    output logic          lock,
    output logic [CW-1:0] err_cnt,
    output logic [7:0]    lat
);

    localparam logic [LCW-1:0] LOCK_TGT   = LCW'(LOCK_CNT);
    localparam logic [LCW-1:0] UNLOCK_TGT = LCW'(UNLOCK_CNT);
    localparam logic [CW-1:0]  ERR_MAX    = '1;

    lane_state_t    state, state_nxt;
    logic [7:0]     exp_val, exp_nxt;
    logic [LCW-1:0] mcnt, mcnt_nxt;
    logic [LCW-1:0] bcnt, bcnt_nxt;
    logic [CW-1:0]  err_nxt;
    logic [7:0]     lat_nxt;
    logic           lock_nxt;

    logic           match;
    logic [LCW-1:0] mcnt_inc;
    logic [LCW-1:0] bcnt_inc;

    assign match    = (rx == exp_val);
    assign mcnt_inc = mcnt + LCW'(1);
    assign bcnt_inc = bcnt + LCW'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            exp_val <= '0;
            mcnt    <= '0;
            bcnt    <= '0;
            err_cnt <= '0;
            lat     <= '0;
            lock    <= 1'b0;
        end else begin
            state   <= state_nxt;
            exp_val <= exp_nxt;
            mcnt    <= mcnt_nxt;
            bcnt    <= bcnt_nxt;
            err_cnt <= err_nxt;
            lat     <= lat_nxt;
            lock    <= lock_nxt;
        end
    end

    // Next-state logic; nothing moves on an invalid cycle
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                HUNT: state_nxt = VERIFY;
                VERIFY: begin
                    if (!match)
                        state_nxt = HUNT;
                    else if (mcnt_inc == LOCK_TGT)
                        state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (!match && (bcnt_inc == UNLOCK_TGT))
                        state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        exp_nxt  = exp_val;
        mcnt_nxt = mcnt;
        bcnt_nxt = bcnt;
        err_nxt  = err_cnt;
        lat_nxt  = lat;
        if (rx_valid) begin
            case (state)
                HUNT: begin
                    exp_nxt  = rx + 8'd1;
                    mcnt_nxt = '0;
                end
                VERIFY: begin
                    if (match) begin
                        exp_nxt  = exp_val + 8'd1;
                        mcnt_nxt = mcnt_inc;
                        if (mcnt_inc == LOCK_TGT) begin
                            lat_nxt  = gen - rx;
                            bcnt_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Expected value always advances so one bad byte cannot slip the lane
                    exp_nxt = exp_val + 8'd1;
                    if (match) begin
                        bcnt_nxt = '0;
                    end else begin
                        bcnt_nxt = bcnt_inc;
                        if (err_cnt != ERR_MAX)
                            err_nxt = err_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
        if (clr_cnt)
            err_nxt = '0;
        lock_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: rtl/pcs_pattern_checker.sv
// -----------------------------------------------------------------------------
// pcs_pattern_checker
// Multi-lane incrementing-byte generator and self-synchronising checker for
// PCS loopback / BIST. Lane i carries (cnt + i) mod 256.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   gen_en      advance the generator one step
//   gen_data    NLANES packed generator bytes (lane i at [8i+7:8i])
//   rx_valid    rx_data qualifier
//   rx_data     NLANES packed decoded receive bytes
//   clr_cnt     clear all error counters
//   lane_lock   per-lane lock status
//   all_lock    registered AND of lane_lock
//   err_cnt     NLANES packed CW-bit saturating error counters
//   lat         NLANES packed latency bytes captured on lock entry
// -----------------------------------------------------------------------------
module pcs_pattern_checker
    import pcs_pattern_pkg::*;
#(
    parameter int unsigned NLANES     = 1,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CW         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_en,
    output logic [NLANES*8-1:0]  gen_data,
    input  logic                 rx_valid,
    input  logic [NLANES*8-1:0]  rx_data,
    input  logic                 clr_cnt,
    output logic [NLANES-1:0]    lane_lock,
    output logic                 all_lock,
    output logic [NLANES*CW-1:0] err_cnt,
    output logic [NLANES*8-1:0]  lat
);

    logic [7:0] cnt;

    // Shared generator; gen_data is kept equal to cnt + lane index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int unsigned i = 0; i < NLANES; i++)
                gen_data[8*i +: 8] <= 8'(i);
        end else if (gen_en) begin
            cnt <= cnt + 8'd1;
            for (int unsigned i = 0; i < NLANES; i++)
                gen_data[8*i +: 8] <= cnt + 8'(i + 1);
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        pcs_lane_checker #(
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_CNT (UNLOCK_CNT),
            .CW         (CW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .rx_valid (rx_valid),
            .rx       (rx_data[8*g +: 8]),
            .gen      (gen_data[8*g +: 8]),
            .clr_cnt  (clr_cnt),
            .lock     (lane_lock[g]),
            .err_cnt  (err_cnt[CW*g +: CW]),
            .lat      (lat[8*g +: 8])
        );
    end

    // all_lock deliberately lags lane_lock by one cycle
    always_ff @(posedge clk) begin
        if (rst)
            all_lock <= 1'b0;
        else
            all_lock <= &lane_lock;
    end

endmodule

// File: tb/tb_pcs_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_pcs_pattern_checker
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares one entry per clock, #1 after the edge.
// -----------------------------------------------------------------------------
module tb_pcs_pattern_checker;

    localparam int unsigned NL  = 2;
    localparam int unsigned LCK = 4;
    localparam int unsigned ULK = 3;
    localparam int unsigned CWB = 4;
    localparam int ERR_MAX = (1 << CWB) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_en;
    logic [15:0] gen_data;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        clr_cnt;
    logic [1:0]  lane_lock;
    logic        all_lock;
    logic [7:0]  err_cnt;
    logic [15:0] lat;

    always #5 clk = ~clk;

    pcs_pattern_checker #(
        .NLANES     (NL),
        .LOCK_CNT   (LCK),
        .UNLOCK_CNT (ULK),
        .CW         (CWB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gen_en    (gen_en),
        .gen_data  (gen_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .clr_cnt   (clr_cnt),
        .lane_lock (lane_lock),
        .all_lock  (all_lock),
        .err_cnt   (err_cnt),
        .lat       (lat)
    );

    typedef struct packed {
        logic [15:0] gen;
        logic [1:0]  lock;
        logic        all;
        logic [7:0]  err;
        logic [15:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: hunting lanes keep the bytes seen since the last seed
    int m_cnt;
    bit m_lock[NL];
    int m_err[NL];
    int m_lat[NL];
    int m_exp[NL];
    int m_miss[NL];
    int hq[NL][$];
    bit m_all;
    int gq[$];

    function automatic int m_gen(int i);
        return (m_cnt + i) % 256;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_all = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_lock[i] = 1'b0;
            m_err[i]  = 0;
            m_lat[i]  = 0;
            m_exp[i]  = 0;
            m_miss[i] = 0;
            hq[i].delete();
        end
    endtask

    task automatic model_step(input bit r, input bit ge, input bit rv,
                              input logic [15:0] rd, input bit cc);
        bit nall;
        int b;
        if (r) begin
            model_reset();
        end else begin
            nall = m_lock[0] && m_lock[1];
            for (int i = 0; i < NL; i++) begin
                b = int'(rd >> (8 * i)) & 255;
                if (rv) begin
                    if (!m_lock[i]) begin
                        hq[i].push_back(b);
                        if (b != (hq[i][0] + hq[i].size() - 1) % 256) begin
                            hq[i].delete();
                        end else if (hq[i].size() == int'(LCK) + 1) begin
                            m_lock[i] = 1'b1;
                            m_lat[i]  = (m_gen(i) - b + 256) % 256;
                            m_exp[i]  = (b + 1) % 256;
                            m_miss[i] = 0;
                            hq[i].delete();
                        end
                    end else begin
                        if (b == m_exp[i]) begin
                            m_miss[i] = 0;
                        end else begin
                            m_err[i]  = (m_err[i] < ERR_MAX) ? m_err[i] + 1 : ERR_MAX;
                            m_miss[i] = m_miss[i] + 1;
                            if (m_miss[i] == int'(ULK)) begin
                                m_lock[i] = 1'b0;
                                hq[i].delete();
                            end
                        end
                        m_exp[i] = (m_exp[i] + 1) % 256;
                    end
                end
                if (cc) m_err[i] = 0;
            end
            m_all = nall;
            if (ge) m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    // Drive one cycle at the falling edge and queue the expected result
    task automatic step(input bit r, input bit ge, input bit rv,
                        input logic [15:0] rd, input bit cc);
        exp_t e;
        @(negedge clk);
        rst      = r;
        gen_en   = ge;
        rx_valid = rv;
        rx_data  = rd;
        clr_cnt  = cc;
        model_step(r, ge, rv, rd, cc);
        e.gen  = {8'(m_gen(1)), 8'(m_gen(0))};
        e.lock = {m_lock[1], m_lock[0]};
        e.all  = m_all;
        e.err  = {4'(m_err[1]), 4'(m_err[0])};
        e.lat  = {8'(m_lat[1]), 8'(m_lat[0])};
        sb.push_back(e);
    endtask

    // Loopback through a 4-word delay line of generator words
    task automatic lb(input logic [15:0] flip, input bit cc, input bit ge, input bit rvm);
        logic [15:0] rd;
        bit rv;
        gq.push_back(int'({8'(m_gen(1)), 8'(m_gen(0))}));
        rv = 1'b0;
        rd = 16'($urandom);
        if (gq.size() > 4) begin
            rd = 16'(gq.pop_front()) ^ flip;
            rv = rvm;
        end
        step(1'b0, ge, rv, rd, cc);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per clock, sampled after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gen_data",  32'(gen_data),  32'(e.gen));
                chk("lane_lock", 32'(lane_lock), 32'(e.lock));
                chk("all_lock",  32'(all_lock),  32'(e.all));
                chk("err_cnt",   32'(err_cnt),   32'(e.err));
                chk("lat",       32'(lat),       32'(e.lat));
            end
        end
    end

    initial begin
        int s;
        rst      = 1'b1;
        gen_en   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        clr_cnt  = 1'b0;
        model_reset();

        // Reset
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Loopback lock and generator wrap
        gq.delete();
        for (int k = 0; k < 300; k++) lb(16'h0, 1'b0, 1'b1, 1'b1);

        // Single bit flip on lane 1
        lb(16'h0100, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) lb(16'h0, 1'b0, 1'b1, 1'b1);

        // Three consecutive lane-0 errors, then relock
        for (int k = 0; k < 3; k++) lb({8'h00, 8'($urandom_range(1, 255))}, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) lb(16'h0, 1'b0, 1'b1, 1'b1);

        // Isolated errors to saturation, then clear colliding with an error
        for (int k = 0; k < 20; k++) begin
            lb({8'h00, 8'($urandom_range(1, 255))}, 1'b0, 1'b1, 1'b1);
            lb(16'h0, 1'b0, 1'b1, 1'b1);
            lb(16'h0, 1'b0, 1'b1, 1'b1);
        end
        lb({8'h00, 8'($urandom_range(1, 255))}, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) lb(16'h0, 1'b0, 1'b1, 1'b1);

        // Lock acquisition with rx_valid toggling, then reset while locked
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        s = int'($urandom_range(0, 255));
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                step(1'b0, 1'b1, 1'b1, {8'(s + 1), 8'(s)}, 1'b0);
                s = s + 1;
            end else begin
                step(1'b0, 1'b1, 1'b0, 16'($urandom), 1'b0);
            end
        end
        step(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Randomised traffic
        gq.delete();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
                gq.delete();
            end else begin
                lb(($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0,
                   $urandom_range(0, 49) == 0,
                   $urandom_range(0, 31) != 0,
                   $urandom_range(0, 7) != 0);
            end
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcs_pattern_checker.md
# pcs_pattern_checker

Multi-lane, parametrised traffic generator and self-synchronising checker for PCS loopback testing. It drives an incrementing byte pattern into one or more 8b/10b transmit datapaths and checks the decoded bytes that return from the receive side. Each lane independently acquires lock, counts errors, tracks loss of lock and measures round-trip latency. It is synthesisable and is used both in simulation benches and on-chip as a built-in self-test for the PCS.

## Interface
Parameters:
- NLANES, 1: number of independent byte lanes.
- LOCK_CNT, 4: consecutive matches required to declare lock (1..15).
- UNLOCK_CNT, 3: consecutive mismatches in LOCKED that force re-hunt (1..15).
- CW, 16: width of each per-lane error counter (saturating).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- gen_en  in  1  advances the generator by one step.
- gen_data  out  NLANES*8  lane i in bits [8i+7:8i]; value is (cnt + i) mod 256.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_data  in  NLANES*8  decoded receive bytes, same lane packing as gen_data.
- clr_cnt  in  1  clears all error counters.
- lane_lock  out  NLANES  per-lane lock status.
- all_lock  out  1  AND of lane_lock.
- err_cnt  out  NLANES*CW  per-lane error count.
- lat  out  NLANES*8  per-lane latency, (gen lane value − rx byte) mod 256, captured on lock entry.

## Operation
- Generator: 8-bit counter cnt, reset to 0, cnt+1 when gen_en=1, wraps 255→0. gen_data is registered, so lane i = i after reset.
- Per-lane checker FSM with states HUNT, VERIFY and LOCKED. Internal registers: exp (8 bits), mcnt, bcnt.
- HUNT: on rx_valid, exp ← rx+1, mcnt ← 0, go to VERIFY.
- VERIFY: on rx_valid:
  - If rx==exp: exp ← exp+1, mcnt+1. When mcnt+1==LOCK_CNT, go to LOCKED and capture lat ← gen lane value − rx.
  - If rx≠exp: go to HUNT. No error is counted.
- LOCKED: on rx_valid, exp ← exp+1 regardless of match, so a single corrupted byte does not desynchronise the lane.
  - On mismatch: err_cnt+1 (saturates at 2^CW−1) and bcnt+1. When bcnt+1==UNLOCK_CNT, go to HUNT.
  - On match: bcnt ← 0.
- rx_valid=0: no state, exp or counter change in any state.
- All arithmetic is mod 256. Expected-value wrap 255→0 is a match, not an error.
- clr_cnt: err_cnt ← 0. If an error occurs in the same cycle, clear wins and the result is 0. clr_cnt does not affect FSM state or lat.
- lat holds its value until the next lock entry. Its value is meaningful only when gen_en was held at 1 throughout the loop.

## Timing
- Reset values: gen_data lane i = i; lane_lock=0; all_lock=0; err_cnt=0; lat=0; all FSMs in HUNT.
- Reset mid-operation aborts lock immediately. Outputs take their reset values the cycle after rst is sampled high.
- All outputs are registered.
- Lock timing: seed at valid word t, matches at valid words t+1..t+LOCK_CNT. lane_lock is high in the cycle after the LOCK_CNT-th match.
- Unlock timing: lane_lock falls in the cycle after the UNLOCK_CNT-th consecutive mismatch. err_cnt updates in the cycle after each mismatch.
- all_lock is registered from lane_lock, so it lags lane_lock by one cycle.

## Structure
- Shared package pcs_pattern_pkg holds the FSM state enum (HUNT/VERIFY/LOCKED) and the lock/unlock count width constant (4 bits).
- Sub-module pcs_lane_checker: one lane's FSM, exp, counters and lat register. Instantiated NLANES times by a generate loop.
- The top level holds the shared generator and the all_lock register.

## Test plan
- Reset, NLANES=2: gen_data = {8'd1, 8'd0}, lane_lock=0, err_cnt=0, lat=0. Hold gen_en=1: lane 0 reads 0,1,2,… and lane 1 reads 1,2,3,…
- Loopback through a 4-cycle delay (rx_valid=1 from first delayed word), LOCK_CNT=4: lane_lock rises 5 valid words after the seed, lat=4 on both lanes, err_cnt stays 0 across the 255→0 wrap.
- While locked, flip bit 0 of one lane-1 byte: err_cnt[1]=1, lane_lock[1] stays 1, lane 0 unaffected, next byte matches.
- While locked, corrupt 3 consecutive lane-0 bytes, UNLOCK_CNT=3: err_cnt[0]=3, lane_lock[0] falls, all_lock falls one cycle later, lane 0 relocks after seed+4 matches.
- CW=4, force 20 isolated errors: err_cnt saturates at 15. Assert clr_cnt together with an error: err_cnt=0 next cycle.
- Toggle rx_valid 1/0 every cycle during lock acquisition: lock needs 4 valid matches, and invalid cycles neither count nor break lock. Assert rst while locked: all outputs return to reset values next cycle.
